custom_axi_ip_sched: RTL
========================

// Module: custom_axi_ip_sched
// PURPOSE
// - Round-robin scheduler sharing one custom_axi_ip processing engine among NUM_REQ requesters.
// - Accepts one request at a time and pulses the engine enable.
// - Waits for engine DONE/ERROR status or a timeout, then returns the result to the granted requester.
// - Sits between the AXI register slices (one per requester) and the single engine instance.
// PARAMETERS
// - NUM_REQ         4     number of requesters, >=2
// - DATA_WIDTH      32    request/response data width; must equal engine width (32)
// - TIMEOUT_CYCLES  64    max cycles in WAIT before an error response, >=4
// PORTS
// - clk_i          in   1                    clock
// - rst_ni         in   1                    reset, asynchronous, active-low
// - req_valid_i    in   NUM_REQ              per-requester request valid
// - req_ready_o    out  NUM_REQ              per-requester request accept, one-hot or zero
// - req_data_i     in   NUM_REQ*DATA_WIDTH   packed request operands; requester k at [k*DW +: DW]
// - rsp_valid_o    out  NUM_REQ              per-requester response valid, one-hot or zero
// - rsp_ready_i    in   NUM_REQ              per-requester response accept
// - rsp_data_o     out  DATA_WIDTH           shared response data
// - rsp_err_o      out  1                    response is error (engine ERROR or timeout)
// - eng_data_o     out  DATA_WIDTH           operand to engine ipreg_data
// - eng_enable_o   out  1                    engine enable_in, 1-cycle pulse
// - eng_data_i     in   DATA_WIDTH           engine ipreg_data_out
// - eng_status_i   in   status_e             engine status_out
// - busy_o         out  1                    high in any state except S_IDLE
// - grant_id_o     out  $clog2(NUM_REQ)      index of current/last granted requester
// BEHAVIOUR
// - Reset: state S_IDLE, rr pointer 0, timeout counter 0. All outputs 0: req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, eng_data_o, eng_enable_o, busy_o, grant_id_o.
// - S_IDLE
//   - Arbiter picks the first asserted req_valid_i at or after the pointer, wrapping.
//   - req_ready_o is asserted for the winner only, in the same cycle.
//   - On handshake: latch operand into eng_data_o, latch winner into grant_id_o, go to S_DISPATCH.
//   - No valid requests: stay in S_IDLE, req_ready_o = 0.
// - S_DISPATCH: eng_enable_o = 1 for exactly this cycle; clear timeout counter; go to S_WAIT.
// - S_WAIT: each cycle, increment the timeout counter, then check in this priority order:
//   - eng_status_i == DONE: rsp_data_o <= eng_data_i, rsp_err_o <= 0, go to S_RESP.
//   - eng_status_i == ERROR: rsp_data_o <= 0, rsp_err_o <= 1, go to S_RESP.
//   - counter == TIMEOUT_CYCLES-1: rsp_data_o <= 0, rsp_err_o <= 1, go to S_RESP.
//   - DONE/ERROR in the same cycle as the timeout wins; the engine result is used.
// - S_RESP
//   - rsp_valid_o[grant_id_o] = 1 and is held until rsp_ready_i[grant_id_o].
//   - rsp_data_o and rsp_err_o are stable while valid.
//   - On handshake: pointer <= (grant_id_o+1) mod NUM_REQ, go to S_IDLE.
//   - rsp_ready_i of non-granted requesters is ignored.
// - Latency
//   - Accept at cycle t; eng_enable_o at t+1.
//   - With the nominal engine (BUSY t+2, DONE t+3), rsp_valid_o rises at t+4.
//   - Minimum request-to-request spacing is 5 cycles.
// - Fairness: a requester that holds valid is granted within NUM_REQ transactions.
// - Requester rule: once asserted, req_valid_i/req_data_i are held until ready; a bench assertion checks this.
// - Requests arriving outside S_IDLE see req_ready_o = 0 and are not lost (requester holds them).
// - Simultaneous events
//   - Response handshake and new valids in the same cycle: the new request is arbitrated in the next cycle (S_IDLE).
//   - The pointer update is applied before that arbitration.
// - Reset mid-operation: in-flight transaction dropped silently, no response; engine is reset by the same rst_ni.
// - Width: timeout counter is $clog2(TIMEOUT_CYCLES)+1 bits, saturating; pointer wraps modulo NUM_REQ (non-power-of-2 supported).
// STRUCTURE
// - custom_axi_ip_pkg (shared) gains:
//   - sched_state_e {S_IDLE, S_DISPATCH, S_WAIT, S_RESP}, 2 bits.
//   - localparam SCHED_TIMEOUT_DEFAULT = 64.
//   - status_e is reused as-is.
// - Sub-module custom_axi_ip_rr_arb (pure combinational): req vector + pointer -> one-hot grant + index + any_valid.
// - FSM, timeout counter and data latches live in custom_axi_ip_sched.
// TESTING
// - Single request: req0 data 0x10 -> eng_enable_o pulse at t+1, rsp_valid_o[0] at t+4, rsp_data_o=0x11, rsp_err_o=0.
// - Contention: all 4 valid continuously -> grants in order 0,1,2,3,0; each gets data+1; no starvation over 20 txns.
// - Engine ERROR: force eng_status_i=ERROR in S_WAIT -> rsp_err_o=1, rsp_data_o=0; next request served normally.
// - Timeout: engine stuck IDLE, TIMEOUT_CYCLES=8 -> rsp_valid_o 8 cycles after dispatch, rsp_err_o=1, data 0.
// - Backpressure: rsp_ready_i low 10 cycles -> rsp_valid_o/data stable; req_ready_o stays 0 on other ports.
// - Reset in S_WAIT: rst_ni low 1 cycle -> all outputs 0, pointer 0, no response; fresh req2 then completes correctly.

Source files
------------

// File: rtl/custom_axi_ip_pkg.sv
// ----------------------------------------------------------------------------
// custom_axi_ip_pkg
// Shared types for the custom_axi_ip engine and its round-robin scheduler.
//   status_e       engine status_out encoding (IDLE/BUSY/DONE/ERROR)
//   sched_state_e  scheduler FSM states
//   SCHED_TIMEOUT_DEFAULT  default WAIT timeout in cycles
// ----------------------------------------------------------------------------
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2,
        S_RESP     = 2'd3
    } sched_state_e;

    localparam int unsigned SCHED_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/custom_axi_ip_rr_arb.sv
// ----------------------------------------------------------------------------
// custom_axi_ip_rr_arb
// Purely combinational round-robin arbiter: grants the first asserted request
// at or after the pointer, wrapping modulo NUM_REQ (any NUM_REQ >= 2).
// Ports:
//   req_i  in   NUM_REQ  request vector
//   ptr_i  in   IDX_W    highest-priority index
//   gnt_o  out  NUM_REQ  one-hot grant (zero when no request)
//   idx_o  out  IDX_W    index of the granted request
//   any_o  out  1        at least one request asserted
// ----------------------------------------------------------------------------
module custom_axi_ip_rr_arb
    import custom_axi_ip_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    localparam int N = int'(NUM_REQ);

    int cand;

    // Scan from the farthest offset down to the pointer itself so the
    // nearest asserted request (lowest offset) is the last one written.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/custom_axi_ip_sched.sv
// ----------------------------------------------------------------------------
// custom_axi_ip_sched
// Round-robin scheduler sharing one custom_axi_ip engine among NUM_REQ
// requesters. One request is accepted at a time, the engine is enabled for a
// single cycle, and the DONE/ERROR status (or a timeout) is returned to the
// granted requester.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  per-requester request handshake (ready one-hot)
//   req_data_i               packed operands, requester k at [k*DW +: DW]
//   rsp_valid_o/rsp_ready_i  per-requester response handshake (valid one-hot)
//   rsp_data_o, rsp_err_o    shared response payload
//   eng_data_o, eng_enable_o operand and enable pulse to the engine
//   eng_data_i, eng_status_i engine result and status
//   busy_o                   scheduler not idle
//   grant_id_o               current/last granted requester
// ----------------------------------------------------------------------------
module custom_axi_ip_sched
    import custom_axi_ip_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned DATA_WIDTH     = 32,
    parameter  int unsigned TIMEOUT_CYCLES = SCHED_TIMEOUT_DEFAULT,
    localparam int unsigned IDX_W          = $clog2(NUM_REQ),
    localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic [DATA_WIDTH-1:0]         eng_data_o,
    output logic                          eng_enable_o,
    input  logic [DATA_WIDTH-1:0]         eng_data_i,
    input  status_e                       eng_status_i,
    output logic                          busy_o,
    output logic [IDX_W-1:0]              grant_id_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]  op_q, op_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    custom_axi_ip_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    op_d    = req_data_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    gnt_d   = arb_idx;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter saturates so it can never wrap back below the limit.
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                // Engine status outranks the timeout when both hit together.
                if (eng_status_i == DONE) begin
                    rsp_data_d = eng_data_i;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (eng_status_i == ERROR) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else if (cnt_d == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i[gnt_q]) begin
                    ptr_d   = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_valid_o[i] = (state_q == S_RESP) && (gnt_q == IDX_W'(i));
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) ? arb_gnt : '0;
    assign eng_enable_o = (state_q == S_DISPATCH);
    assign busy_o       = (state_q != S_IDLE);
    assign grant_id_o   = gnt_q;
    assign eng_data_o   = op_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
